// File: rtl/ucie_ctl_sb_tx_serializer.sv
// Sideband TX serializer: buffers a 64-bit header and 64-bit data message, and
// streams one 32-bit phase onto the NC-bit RDI lp_cfg bus under FSM load/shift control.
module ucie_ctl_sb_tx_serializer #(
  parameter int NC      = 32,
  parameter int PHASE_W = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [63:0]   i_hdr,
  input  logic [63:0]   i_data,
  input  logic [1:0]    i_buf_en,
  input  logic [1:0]    i_shift_load,
  input  logic [1:0]    i_phase_sel,
  output logic [NC-1:0] o_lp_cfg,
  output logic          o_beat_vld,
  output logic          o_done_shift,
  output logic          o_underrun
);

  localparam int         BPP    = PHASE_W / NC;
  localparam logic [1:0] BPP_M1 = 2'(BPP - 1);

  typedef enum logic {IDLE, SHIFTING} state_e;

  state_e               state_q;
  logic [63:0]          hdr_q, data_q;
  logic [PHASE_W-1:0]   shreg_q;
  logic [1:0]           beats_q;
  logic [NC-1:0]        lp_cfg_q;
  logic                 vld_q, done_q, unr_q;
  logic [PHASE_W-1:0]   phase_d;

  always_comb begin
    phase_d = '0;
    case (i_phase_sel)
      2'd0: phase_d = hdr_q[31:0];
      2'd1: phase_d = hdr_q[63:32];
      2'd2: phase_d = data_q[31:0];
      default: phase_d = data_q[63:32];
    endcase
  end

  // Buffer capture runs regardless of serializer state; load sees pre-edge contents.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hdr_q  <= '0;
      data_q <= '0;
    end else begin
      if (i_buf_en[0]) hdr_q  <= i_hdr;
      if (i_buf_en[1]) data_q <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      beats_q  <= '0;
      lp_cfg_q <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      unr_q    <= 1'b0;
    end else begin
      case (i_shift_load)
        2'b01: begin
          // Load wins in any state; pending beats of an earlier phase are dropped.
          lp_cfg_q <= phase_d[NC-1:0];
          shreg_q  <= phase_d >> NC;
          beats_q  <= BPP_M1;
          vld_q    <= 1'b1;
          unr_q    <= 1'b0;
          if (BPP == 1) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            done_q  <= 1'b0;
            state_q <= SHIFTING;
          end
        end
        2'b10: begin
          if (state_q == SHIFTING) begin
            lp_cfg_q <= shreg_q[NC-1:0];
            shreg_q  <= shreg_q >> NC;
            beats_q  <= beats_q - 2'd1;
            vld_q    <= 1'b1;
            if (beats_q == 2'd1) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              done_q  <= 1'b0;
            end
          end else begin
            unr_q  <= 1'b1;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
          end
        end
        default: begin
          vld_q  <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_lp_cfg     = lp_cfg_q;
  assign o_beat_vld   = vld_q;
  assign o_done_shift = done_q;
  assign o_underrun   = unr_q;

endmodule

// File: tb/tb_ucie_ctl_sb_tx_serializer.sv
// Directed bench: three serializer instances (NC = 32, 16, 8) share stimulus; each
// scenario checks the instance whose bus width it targets.
module tb_ucie_ctl_sb_tx_serializer;

  logic        clk, rst_n;
  logic [63:0] hdr, data;
  logic [1:0]  buf_en, sl, sel;

  logic [31:0] lp32;
  logic [15:0] lp16;
  logic [7:0]  lp8;
  logic        vld32, done32, unr32;
  logic        vld16, done16, unr16;
  logic        vld8,  done8,  unr8;

  int checks   = 0;
  int failures = 0;

  ucie_ctl_sb_tx_serializer #(.NC(32)) u32 (
    .i_clk(clk), .i_rst(rst_n), .i_hdr(hdr), .i_data(data), .i_buf_en(buf_en),
    .i_shift_load(sl), .i_phase_sel(sel), .o_lp_cfg(lp32), .o_beat_vld(vld32),
    .o_done_shift(done32), .o_underrun(unr32));

  ucie_ctl_sb_tx_serializer #(.NC(16)) u16 (
    .i_clk(clk), .i_rst(rst_n), .i_hdr(hdr), .i_data(data), .i_buf_en(buf_en),
    .i_shift_load(sl), .i_phase_sel(sel), .o_lp_cfg(lp16), .o_beat_vld(vld16),
    .o_done_shift(done16), .o_underrun(unr16));

  ucie_ctl_sb_tx_serializer #(.NC(8)) u8 (
    .i_clk(clk), .i_rst(rst_n), .i_hdr(hdr), .i_data(data), .i_buf_en(buf_en),
    .i_shift_load(sl), .i_phase_sel(sel), .o_lp_cfg(lp8), .o_beat_vld(vld8),
    .o_done_shift(done8), .o_underrun(unr8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply a command for one edge, then sample 1ns after that edge.
  task automatic step(input logic [1:0] cmd, input logic [1:0] psel, input logic [1:0] ben);
    sl = cmd; sel = psel; buf_en = ben;
    @(posedge clk); #1;
    sl = 2'b00; buf_en = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; hdr = '0; data = '0; buf_en = '0; sl = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lp32", lp32, 32'h0);
    chk("rst_vld32", 32'(vld32), 32'h0);
    chk("rst_done16", 32'(done16), 32'h0);
    chk("rst_unr8", 32'(unr8), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // NC=32: four back-to-back single-beat phases
    hdr  = 64'hAAAA_BBBB_1111_2222;
    data = 64'hCCCC_DDDD_3333_4444;
    step(2'b00, 2'd0, 2'b11);
    step(2'b01, 2'd0, 2'b00);
    chk("n32_p0", lp32, 32'h1111_2222); chk("n32_p0_done", 32'(done32), 32'h1);
    step(2'b01, 2'd1, 2'b00);
    chk("n32_p1", lp32, 32'hAAAA_BBBB); chk("n32_p1_done", 32'(done32), 32'h1);
    step(2'b01, 2'd2, 2'b00);
    chk("n32_p2", lp32, 32'h3333_4444); chk("n32_p2_vld", 32'(vld32), 32'h1);
    step(2'b01, 2'd3, 2'b00);
    chk("n32_p3", lp32, 32'hCCCC_DDDD); chk("n32_p3_done", 32'(done32), 32'h1);

    // NC=16: two-beat phase
    step(2'b01, 2'd0, 2'b00);
    chk("n16_b0", 32'(lp16), 32'h2222); chk("n16_b0_done", 32'(done16), 32'h0);
    chk("n16_b0_vld", 32'(vld16), 32'h1);
    step(2'b10, 2'd0, 2'b00);
    chk("n16_b1", 32'(lp16), 32'h1111); chk("n16_b1_done", 32'(done16), 32'h1);
    step(2'b00, 2'd0, 2'b00);
    chk("n16_hold_vld", 32'(vld16), 32'h0); chk("n16_hold_done", 32'(done16), 32'h0);

    // NC=16: shift while idle raises sticky underrun; next load clears it
    step(2'b10, 2'd0, 2'b00);
    chk("n16_unr", 32'(unr16), 32'h1); chk("n16_unr_vld", 32'(vld16), 32'h0);
    chk("n16_unr_lp", 32'(lp16), 32'h1111);
    step(2'b00, 2'd0, 2'b00);
    chk("n16_unr_sticky", 32'(unr16), 32'h1);
    step(2'b01, 2'd0, 2'b00);
    chk("n16_unr_clr", 32'(unr16), 32'h0); chk("n16_unr_ld", 32'(lp16), 32'h2222);

    // NC=16: load interrupts a phase mid-way
    step(2'b01, 2'd1, 2'b00);
    chk("n16_int_lo", 32'(lp16), 32'hBBBB); chk("n16_int_done0", 32'(done16), 32'h0);
    step(2'b10, 2'd0, 2'b00);
    chk("n16_int_hi", 32'(lp16), 32'hAAAA); chk("n16_int_done1", 32'(done16), 32'h1);

    // NC=8: four beats with a hold in the middle
    data = 64'h0123_4567_DEAD_BEEF;
    step(2'b00, 2'd0, 2'b10);
    step(2'b01, 2'd2, 2'b00);
    chk("n8_b0", 32'(lp8), 32'hEF); chk("n8_b0_done", 32'(done8), 32'h0);
    step(2'b10, 2'd0, 2'b00);
    chk("n8_b1", 32'(lp8), 32'hBE);
    step(2'b00, 2'd0, 2'b00);
    chk("n8_hold_vld", 32'(vld8), 32'h0); chk("n8_hold_lp", 32'(lp8), 32'hBE);
    step(2'b10, 2'd0, 2'b00);
    chk("n8_b2", 32'(lp8), 32'hAD); chk("n8_b2_done", 32'(done8), 32'h0);
    step(2'b10, 2'd0, 2'b00);
    chk("n8_b3", 32'(lp8), 32'hDE); chk("n8_b3_done", 32'(done8), 32'h1);
    chk("n8_b3_vld", 32'(vld8), 32'h1);

    // Same-cycle capture is not visible to the load
    data = 64'h0000_0000_CAFE_F00D;
    step(2'b01, 2'd2, 2'b10);
    chk("cap_old", lp32, 32'hDEAD_BEEF);
    step(2'b01, 2'd2, 2'b00);
    chk("cap_new", lp32, 32'hCAFE_F00D);

    // Async reset mid-phase
    step(2'b01, 2'd2, 2'b00);
    chk("pre_rst_lp8", 32'(lp8), 32'h0D);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lp8", 32'(lp8), 32'h0);
    chk("arst_vld8", 32'(vld8), 32'h0);
    chk("arst_lp32", lp32, 32'h0);
    chk("arst_done32", 32'(done32), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2'b01, 2'd2, 2'b00);
    chk("post_rst_lp32", lp32, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
